// File: rtl/led_defs.sv
// Shared constants, state encodings and helpers for the multiplexed 7-segment LED controller.
// Segment bytes are {dp,g,f,e,d,c,b,a}, active-high.
package led_defs;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_MINUS = 8'h40;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FORMAT = 2'd2
  } ctrl_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led_display_controller_if.sv
// Control-side bundle between the calculator and the LED display controller.
// Handshake: load is a one-cycle request that is accepted only while busy=0; a load seen
// while busy=1 is dropped (no queueing). busy falls on the cycle the display buffer commits.
interface led_display_controller_if #(
  parameter int BIN_W = 14
);
  logic [BIN_W-1:0] value;
  logic             neg;
  logic             load;
  logic             blank_lz;
  logic             blink;
  logic             busy;
  logic             ovf;

  modport master (output value, neg, load, blank_lz, blink, input busy, ovf);
  modport slave  (input value, neg, load, blank_lz, blink, output busy, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: start captures bin and performs the first step,
// then one step per cycle until all BIN_W bits are shifted in; done is high while idle.
module bin2bcd_seq
  import led_defs::*;
#(
  parameter int BIN_W = 14,
  parameter int BCD_W = 4 * (((BIN_W + 1) * 302 + 999) / 1000)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);
  localparam int NDIG  = BCD_W / 4;
  localparam int CNT_W = clog2(BIN_W + 1);

  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start) begin
      // Adjusting an all-zero BCD is a no-op, so the first step is just the shift-in.
      bcd_d = {{(BCD_W-1){1'b0}}, bin[BIN_W-1]};
      bin_d = bin << 1;
      cnt_d = CNT_W'(BIN_W - 1);
    end else if (cnt_q != '0) begin
      bcd_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
      bin_d = bin_q << 1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);
  assign bcd  = bcd_q;

endmodule

// File: rtl/led_display_controller.sv
// Multiplexed 7-segment display controller: sequential BCD conversion, formatting with
// leading-zero blanking, minus sign and overflow dashes, double-buffered scan with blink.
module led_display_controller
  import led_defs::*;
#(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int CLK_FREQ = 50_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  led_display_controller_if.slave ctrl,
  output logic [DIGITS-1:0]       com,
  output logic [7:0]              seg,
  output ctrl_state_e             dbg_state_o
);
  localparam int BCD_W     = 4 * (((BIN_W + 1) * 302 + 999) / 1000);
  localparam int NBCD      = BCD_W / 4;
  localparam int EXT_D     = ((NBCD > DIGITS) ? NBCD : DIGITS) + 1;
  localparam int SCAN_DIV  = CLK_FREQ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
  localparam int SCAN_W    = clog2(SCAN_DIV + 1);
  localparam int BLINK_W   = clog2(BLINK_DIV + 1);
  localparam int IDX_W     = clog2(DIGITS);

  ctrl_state_e              state_q;
  logic                     busy_q, ovf_q, neg_q;
  logic [DIGITS-1:0][7:0]   buf_q, buf_d, fmt_segs;
  logic                     fmt_ovf;
  logic                     bcd_start, bcd_done;
  logic [BCD_W-1:0]         bcd;
  logic [4*EXT_D-1:0]       bcd_ext;
  logic [DIGITS-1:0][3:0]   dig;
  int                       msd, minus_pos;

  logic [SCAN_W-1:0]        scan_cnt_q;
  logic [BLINK_W-1:0]       blink_cnt_q;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     started_q, started_d, phase_q, phase_d;
  logic                     scan_tick, blink_tick, show;
  logic [DIGITS-1:0]        com_q;
  logic [7:0]               seg_q;

  assign bcd_start = (state_q == ST_IDLE) && ctrl.load;

  bin2bcd_seq #(.BIN_W(BIN_W), .BCD_W(BCD_W)) u_bcd (
    .clk   (clk),
    .rst_n (reset),
    .start (bcd_start),
    .bin   (ctrl.value),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  // Zero-extended so digits beyond the converter width read as 0 and overflow is a simple OR.
  assign bcd_ext = {{(4*EXT_D-BCD_W){1'b0}}, bcd};

  always_comb begin
    dig       = '0;
    msd       = -1;
    minus_pos = DIGITS - 1;
    fmt_segs  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig[i] = bcd_ext[4*i +: 4];
      if (dig[i] != 4'd0) msd = i;
    end
    fmt_ovf = (|(bcd_ext >> (4*DIGITS))) || (neg_q && (dig[DIGITS-1] != 4'd0));
    if (ctrl.blank_lz) minus_pos = msd + 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (ctrl.blank_lz && (i > msd) && (i != 0)) fmt_segs[i] = SEG_BLANK;
      else                                        fmt_segs[i] = seg_of(dig[i]);
      if (neg_q && (msd >= 0) && (i == minus_pos)) fmt_segs[i] = SEG_MINUS;
    end
    if (fmt_ovf) fmt_segs = {DIGITS{SEG_MINUS}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (ctrl.load) begin
          state_q <= ST_SHIFT;
          busy_q  <= 1'b1;
          neg_q   <= ctrl.neg;
        end
        ST_SHIFT: if (bcd_done) state_q <= ST_FORMAT;
        ST_FORMAT: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          buf_q   <= fmt_segs;
          ovf_q   <= fmt_ovf;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Scan outputs are built from next-state values so a commit or tick is visible on the same edge.
  assign buf_d      = (state_q == ST_FORMAT) ? fmt_segs : buf_q;
  assign scan_tick  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
  assign blink_tick = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
  assign idx_d      = !scan_tick ? idx_q :
                      (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
  assign started_d  = started_q | scan_tick;
  assign phase_d    = phase_q ^ blink_tick;
  assign show       = started_d & ~(ctrl.blink & phase_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      idx_q       <= '0;
      started_q   <= 1'b0;
      phase_q     <= 1'b0;
      com_q       <= '1;
      seg_q       <= SEG_BLANK;
    end else begin
      scan_cnt_q  <= scan_tick ? '0 : scan_cnt_q + 1'b1;
      blink_cnt_q <= blink_tick ? '0 : blink_cnt_q + 1'b1;
      idx_q       <= idx_d;
      started_q   <= started_d;
      phase_q     <= phase_d;
      com_q       <= show ? ~(DIGITS'(1) << idx_d) : '1;
      seg_q       <= show ? buf_d[idx_d] : SEG_BLANK;
    end
  end

  assign com         = com_q;
  assign seg         = seg_q;
  assign ctrl.busy   = busy_q;
  assign ctrl.ovf    = ovf_q;
  assign dbg_state_o = state_q;

endmodule
